uart_tx_fifo: RTL and testbench

Transmit holding FIFO for the UART 16550 core, sitting between the CPU-side THR write path and the transmit serializer. Buffers up to 16 characters written by the bus interface, presents the head character first-word-fall-through on `dout`, and advances once per rising edge of the serializer's level-held `pop`. Generates the `thre` status consumed by the serializer and by the LSR/interrupt logic, and supports 16450 single-byte mode (FCR[0]=0) and FCR[2] flush.

---
 rtl/uart_tx_fifo_if.sv | 49 ++++
 rtl/uart_tx_fifo.sv | 108 ++++++++++
 tb/tb_uart_tx_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Signal bundle between the THR write path / transmit serializer and the
// 16550 transmit holding FIFO.
//
//   master : the bus/serializer side. It drives en, clr, push, din and pop.
//            It observes dout, empty, full, thre, count and overrun.
//   slave  : the FIFO side, with the opposite directions.
//
//   en      FCR[0] FIFO enable (0 = 16450 single-byte mode)
//   clr     FCR[2] TX FIFO reset pulse
//   push    THR write strobe
//   din     THR write data
//   pop     serializer read request (level; each rising edge consumes one)
//   dout    head-of-queue character, first-word-fall-through, 0 when empty
//   empty   no characters stored
//   full    count equals current capacity
//   thre    LSR THRE, identical to empty
//   count   characters stored
//   overrun one-cycle pulse after a push was rejected because the FIFO was full
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             en;
   logic             clr;
   logic             push;
   logic [WIDTH-1:0] din;
   logic             pop;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
   logic             thre;
   logic [CW-1:0]    count;
   logic             overrun;

   modport master (
      output en, clr, push, din, pop,
      input  dout, empty, full, thre, count, overrun
   );

   modport slave (
      input  en, clr, push, din, pop,
      output dout, empty, full, thre, count, overrun
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Transmit holding FIFO for the UART 16550 core. The FIFO buffers characters
// written through THR and presents the oldest one on dout as a
// first-word-fall-through output. It advances once for each rising edge of the
// serializer's level-held pop. Capacity is DEPTH in FIFO mode (en=1) and 1 in
// 16450 mode (en=0). A clr pulse, or any change of en, flushes the contents.
//
// Ports
//   clk  core clock
//   rst  synchronous, active-high reset
//   bus  uart_tx_fifo_if.slave: en, clr, push, din, pop in;
//        dout, empty, full, thre, count, overrun out
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_fifo_if.slave      bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             pop_d;
   logic             en_d;
   logic             overrun_q;

   logic [CW-1:0]    capacity;
   logic             empty_c;
   logic             full_c;
   logic             pop_evt;
   logic             flush;
   logic             do_pop;
   logic             do_push;
   logic             ovr_req;

   // NOTE: every signal driven in always_comb receives a default first, so
   // that no path leaves it unassigned and no latch is inferred.
   always_comb begin
      capacity = bus.en ? CW'(DEPTH) : CW'(1);
      empty_c  = (count_q == '0);
      full_c   = (count_q == capacity);
      // Only the rising edge of pop consumes a character.
      pop_evt  = bus.pop & ~pop_d;
      // A mode change flushes the FIFO exactly as FCR[2] does.
      flush    = bus.clr | (en_d != bus.en);
      do_pop   = pop_evt & ~empty_c;
      // When the FIFO is full, a pop in the same cycle frees the slot first.
      do_push  = bus.push & (~full_c | do_pop);
      ovr_req  = bus.push & full_c & ~pop_evt;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         pop_d     <= 1'b0;
         en_d      <= bus.en;
         overrun_q <= 1'b0;
      end else begin
         // pop_d and en_d keep tracking during a flush. Then a held pop is
         // not counted again later, and the flush does not repeat.
         pop_d <= bus.pop;
         en_d  <= bus.en;
         if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
               count_q <= count_q + CW'(1);
            else if (do_pop && !do_push)
               count_q <= count_q - CW'(1);
            overrun_q <= ovr_req;
         end
      end
   end

   // NOTE: the storage array is deliberately not reset. The pointers and the
   // count define which entries are valid, so resetting the array would add
   // cost without changing behaviour.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= bus.din;
   end

   // dout comes from registered state only. The serializer can therefore latch
   // dout in the same cycle that it raises pop.
   assign bus.dout    = empty_c ? '0 : mem[rd_ptr];
   assign bus.empty   = empty_c;
   assign bus.thre    = empty_c;
   assign bus.full    = full_c;
   assign bus.count   = count_q;
   assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed self-checking bench for uart_tx_fifo. Inputs are driven 1 ns after
// each rising edge. Outputs are sampled at that same point, once the edge has
// settled.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   uart_tx_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.push = 1'b1;
      bus.din  = b;
      step();
      bus.push = 1'b0;
   endtask

   task automatic pop_pulse(input int len);
      bus.pop = 1'b1;
      repeat (len) step();
      bus.pop = 1'b0;
      step();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " count"},   32'(bus.count), 0);
      check({tag, " empty"},   32'(bus.empty), 1);
      check({tag, " thre"},    32'(bus.thre),  1);
      check({tag, " full"},    32'(bus.full),  0);
      check({tag, " overrun"}, 32'(bus.overrun), 0);
      check({tag, " dout"},    32'(bus.dout),  0);
   endtask

   initial begin
      bus.en   = 1'b1;
      bus.clr  = 1'b0;
      bus.push = 1'b0;
      bus.din  = '0;
      bus.pop  = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check_reset_state("reset");

      // Three characters in, then three 20-cycle pop pulses.
      push_byte(8'h41);
      push_byte(8'h42);
      push_byte(8'h43);
      check("abc count", 32'(bus.count), 3);
      check("abc dout",  32'(bus.dout),  32'h41);
      check("abc thre",  32'(bus.thre),  0);
      pop_pulse(20);
      check("pop1 dout", 32'(bus.dout), 32'h42);
      pop_pulse(20);
      check("pop2 dout", 32'(bus.dout), 32'h43);
      pop_pulse(20);
      check("pop3 dout",  32'(bus.dout),  0);
      check("pop3 empty", 32'(bus.empty), 1);
      check("pop3 thre",  32'(bus.thre),  1);

      // A long pop level consumes exactly one character.
      push_byte(8'h11);
      push_byte(8'h22);
      pop_pulse(200);
      check("hold count", 32'(bus.count), 1);
      check("hold dout",  32'(bus.dout),  32'h22);
      pop_pulse(1);
      check("hold drain", 32'(bus.empty), 1);

      // Fill to 16, then attempt a 17th push to get an overrun.
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      check("fill full",  32'(bus.full),  1);
      check("fill count", 32'(bus.count), 16);
      check("fill ovr0",  32'(bus.overrun), 0);
      push_byte(8'h10);
      check("ovr pulse", 32'(bus.overrun), 1);
      check("ovr count", 32'(bus.count), 16);
      step();
      check("ovr clear", 32'(bus.overrun), 0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("fill order %0d", i), 32'(bus.dout), 32'(i));
         pop_pulse(1);
      end
      check("fill drained", 32'(bus.empty), 1);

      // Pointer wrap: three characters in flight, 40 simultaneous push/pop pairs.
      push_byte(8'h80);
      push_byte(8'h81);
      push_byte(8'h82);
      for (int i = 0; i < 40; i++) begin
         check($sformatf("wrap %0d", i), 32'(bus.dout), 32'(8'h80 + i));
         bus.push = 1'b1;
         bus.din  = 8'(8'h83 + i);
         bus.pop  = 1'b1;
         step();
         bus.push = 1'b0;
         bus.pop  = 1'b0;
         step();
      end
      check("wrap count", 32'(bus.count), 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("wrap tail %0d", i), 32'(bus.dout), 32'(8'hA8 + i));
         pop_pulse(1);
      end
      check("wrap empty", 32'(bus.empty), 1);

      // When the FIFO is full, a push with a pop edge in the same cycle is accepted.
      for (int i = 0; i < 16; i++) push_byte(8'(8'h60 + i));
      bus.push = 1'b1;
      bus.din  = 8'hAA;
      bus.pop  = 1'b1;
      step();
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      check("fullpp count", 32'(bus.count), 16);
      check("fullpp ovr",   32'(bus.overrun), 0);
      step();
      for (int i = 0; i < 15; i++) begin
         check($sformatf("fullpp order %0d", i), 32'(bus.dout), 32'(8'h61 + i));
         pop_pulse(1);
      end
      check("fullpp 16th", 32'(bus.dout), 32'hAA);
      pop_pulse(1);
      check("fullpp empty", 32'(bus.empty), 1);

      // 16450 mode: capacity 1.
      bus.en = 1'b0;
      step();
      step();
      push_byte(8'h55);
      push_byte(8'h66);
      check("m16450 ovr",   32'(bus.overrun), 1);
      check("m16450 count", 32'(bus.count), 1);
      check("m16450 full",  32'(bus.full),  1);
      check("m16450 dout",  32'(bus.dout),  32'h55);
      bus.en = 1'b1;
      step();
      check("en flip count", 32'(bus.count), 0);
      check("en flip thre",  32'(bus.thre),  1);
      check("en flip ovr",   32'(bus.overrun), 0);

      // A clr in the same cycle as a push discards that push.
      for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
      check("clr pre count", 32'(bus.count), 5);
      bus.clr  = 1'b1;
      bus.push = 1'b1;
      bus.din  = 8'h99;
      step();
      bus.clr  = 1'b0;
      bus.push = 1'b0;
      check("clr count", 32'(bus.count), 0);
      check("clr empty", 32'(bus.empty), 1);
      check("clr dout",  32'(bus.dout),  0);
      step();
      check("clr discard", 32'(bus.count), 0);
      push_byte(8'h77);
      check("post clr dout",  32'(bus.dout),  32'h77);
      check("post clr count", 32'(bus.count), 1);
      pop_pulse(1);

      // Reset in the middle of a fill.
      for (int i = 0; i < 7; i++) push_byte(8'(8'h20 + i));
      check("mid count", 32'(bus.count), 7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_state("midreset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
